// File: rtl/lfsr_prng.sv
// Parametrised Galois LFSR with runtime reseed, zero-seed guard and an N-bit draw handshake.
// Optional step-period monitor (wrap_o/period_o) enabled by defining LFSR_WRAP_DETECT_EN.
module lfsr_prng #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
  parameter int               OUT_BITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    seed_i,
  input  logic                req_i,
  output logic                nextbit_o,
  output logic [WIDTH-1:0]    state_o,
  output logic [OUT_BITS-1:0] rand_o,
  output logic                valid_o,
  output logic                busy_o
`ifdef LFSR_WRAP_DETECT_EN
  ,
  output logic                wrap_o,
  output logic [WIDTH-1:0]    period_o
`endif
);

  localparam int CNT_W = $clog2(OUT_BITS + 1);

  generate
    if (SEED == '0) begin : g_bad_seed
      $error("lfsr_prng: SEED must be nonzero");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_prng: WIDTH must be in 2..32");
    end
    if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
      $error("lfsr_prng: OUT_BITS must be in 1..WIDTH");
    end
  endgenerate

  // Handshake: req_i is accepted only while busy_o is low; the drawn word is
  // presented on rand_o together with a single-cycle valid_o pulse (no back-pressure).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  fsm_t                r_fsm, w_fsm_nxt;
  logic [WIDTH-1:0]    r_state, w_state_nxt, w_step, w_load_val;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [OUT_BITS-1:0] r_rand, w_rand_nxt;
  logic                w_stepping;

  always_comb begin
    w_step     = {1'b0, r_state[WIDTH-1:1]} ^ (r_state[0] ? TAPS : '0);
    w_load_val = (seed_i == '0) ? SEED : seed_i;
  end

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_cnt_nxt  = r_cnt;
    w_rand_nxt = r_rand;
    w_stepping = 1'b0;
    if (load_i) begin
      // Reseed aborts any draw; rand_o keeps whatever it already holds.
      w_fsm_nxt = S_IDLE;
      w_cnt_nxt = '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (req_i) begin
            w_fsm_nxt = S_SHIFT;
            w_cnt_nxt = '0;
          end else begin
            w_stepping = en_i;
          end
        end
        S_SHIFT: begin
          w_stepping = 1'b1;
          for (int b = 0; b < OUT_BITS; b++) begin
            if (r_cnt == CNT_W'(b)) w_rand_nxt[b] = r_state[0];
          end
          if (r_cnt == CNT_W'(OUT_BITS - 1)) w_fsm_nxt = S_DONE;
          else                               w_cnt_nxt = r_cnt + 1'b1;
        end
        S_DONE:  w_fsm_nxt = S_IDLE;
        default: w_fsm_nxt = S_IDLE;
      endcase
    end
    if (load_i)          w_state_nxt = w_load_val;
    else if (w_stepping) w_state_nxt = w_step;
    else                 w_state_nxt = r_state;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm   <= S_IDLE;
      r_cnt   <= '0;
      r_rand  <= '0;
      r_state <= SEED;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rand  <= w_rand_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign nextbit_o = r_state[0];
  assign state_o   = r_state;
  assign rand_o    = r_rand;
  assign valid_o   = (r_fsm == S_DONE);
  assign busy_o    = (r_fsm != S_IDLE);

`ifdef LFSR_WRAP_DETECT_EN
  logic [WIDTH-1:0] r_wcnt, r_last_seed, r_period;
  logic             r_wrap;

  // Period is measured against the most recently loaded seed, not the reset seed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wcnt      <= '0;
      r_last_seed <= SEED;
      r_period    <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load_i) begin
        r_wcnt      <= '0;
        r_last_seed <= w_load_val;
      end else if (w_stepping) begin
        if (w_step == r_last_seed) begin
          r_wrap   <= 1'b1;
          r_period <= r_wcnt + 1'b1;
          r_wcnt   <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
    end
  end

  assign wrap_o   = r_wrap;
  assign period_o = r_period;
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: reset, free run, draw handshake, reseed abort and back-to-back draws.
// With LFSR_WRAP_DETECT_EN defined a second 4-bit instance checks the period monitor.
module tb_lfsr_prng;

  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk_i = 1'b0;
  logic        rst_i, en_i, load_i, req_i;
  logic [15:0] seed_i;
  logic        nextbit_o, valid_o, busy_o;
  logic [15:0] state_o;
  logic [3:0]  rand_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_state;
  logic [3:0]  exp_q[$];

  always #5 clk_i = ~clk_i;

`ifdef LFSR_WRAP_DETECT_EN
  logic        wrap16, wrap4;
  logic [15:0] period16;
  logic        en4, nextbit4, valid4, busy4;
  logic [3:0]  state4, rand4, period4;

  lfsr_prng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_BITS(4)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en4), .load_i(1'b0), .seed_i(4'h0),
    .req_i(1'b0), .nextbit_o(nextbit4), .state_o(state4), .rand_o(rand4),
    .valid_o(valid4), .busy_o(busy4), .wrap_o(wrap4), .period_o(period4)
  );
`endif

  lfsr_prng u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .load_i(load_i), .seed_i(seed_i),
    .req_i(req_i), .nextbit_o(nextbit_o), .state_o(state_o), .rand_o(rand_o),
    .valid_o(valid_o), .busy_o(busy_o)
`ifdef LFSR_WRAP_DETECT_EN
    , .wrap_o(wrap16), .period_o(period16)
`endif
  );

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_state(input logic [15:0] exp);
    n_checks++;
    if (state_o !== exp || nextbit_o !== exp[0]) begin
      n_fail++;
      $display("FAIL state: got %h/%b expected %h/%b", state_o, nextbit_o, exp, exp[0]);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; en_i = 1'b0; load_i = 1'b0; req_i = 1'b0; seed_i = '0;
`ifdef LFSR_WRAP_DETECT_EN
    en4 = 1'b0;
`endif
    tick(); tick();
    rst_i = 1'b0;
    m_state = SEED;
    n_checks++;
    if (state_o !== 16'hACE1 || nextbit_o !== 1'b1 || valid_o !== 1'b0 ||
        busy_o !== 1'b0 || rand_o !== 4'h0) begin
      n_fail++;
      $display("FAIL reset: got state=%h nb=%b v=%b b=%b r=%h expected ace1/1/0/0/0",
               state_o, nextbit_o, valid_o, busy_o, rand_o);
    end
  endtask

  task automatic test_free_run();
    logic [15:0] vec [4];
    vec[0] = 16'hE270; vec[1] = 16'h7138; vec[2] = 16'h389C; vec[3] = 16'h1C4E;
    en_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (state_o !== vec[i]) begin
        n_fail++;
        $display("FAIL free_run_vec%0d: got %h expected %h", i, state_o, vec[i]);
      end
    end
    m_state = 16'h1C4E;
    for (int i = 0; i < 40; i++) begin
      en_i = 1'($urandom_range(0, 1));
      tick();
      if (en_i) m_state = m_step(m_state);
      chk_state(m_state);
    end
    en_i = 1'b0;
  endtask

  // One complete draw from IDLE; en_i is randomised throughout and must only matter in IDLE.
  task automatic do_draw(input logic force_en);
    logic [3:0] w;
    req_i = 1'b1;
    en_i  = force_en ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    req_i = 1'b0;
    chk_state(m_state);
    n_checks++;
    if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL draw_accept: got busy=%b valid=%b expected 1/0", busy_o, valid_o);
    end
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[i] = m_state[0];
      m_state = m_step(m_state);
      en_i = 1'($urandom_range(0, 1));
      tick();
      chk_state(m_state);
      n_checks++;
      if (busy_o !== 1'b1 || valid_o !== (i == 3)) begin
        n_fail++;
        $display("FAIL draw_step%0d: got busy=%b valid=%b expected 1/%b", i, busy_o, valid_o, i == 3);
      end
    end
    exp_q.push_back(w);
    if (valid_o === 1'b1 && exp_q.size() > 0) begin
      n_checks++;
      if (rand_o !== exp_q[0]) begin
        n_fail++;
        $display("FAIL draw_word: got %b expected %b", rand_o, exp_q[0]);
      end
    end
    void'(exp_q.pop_front());
    en_i = 1'($urandom_range(0, 1));
    tick();
    chk_state(m_state);
    n_checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL draw_done: got busy=%b valid=%b expected 0/0", busy_o, valid_o);
    end
    en_i = 1'b0;
  endtask

  task automatic test_draw();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    m_state = SEED;
    do_draw(1'b0);
    n_checks++;
    if (rand_o !== 4'b0001 || state_o !== 16'h1C4E) begin
      n_fail++;
      $display("FAIL draw_vec: got rand=%b state=%h expected 0001/1c4e", rand_o, state_o);
    end
    for (int d = 0; d < 8; d++) begin
      load_i = 1'b1;
      seed_i = 16'($urandom_range(1, 16'hFFFF));
      tick();
      load_i = 1'b0;
      m_state = seed_i;
      chk_state(m_state);
      do_draw(1'b0);
    end
  endtask

  task automatic test_req_with_en();
    do_draw(1'b1);
  endtask

  task automatic test_load_abort();
    for (int k = 0; k < 4; k++) begin
      req_i = 1'b1;
      tick();
      req_i = 1'b0;
      for (int i = 0; i < k; i++) begin
        m_state = m_step(m_state);
        tick();
      end
      load_i = 1'b1;
      seed_i = (k == 3) ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0000;
      tick();
      load_i = 1'b0;
      m_state = (seed_i == 16'h0000) ? SEED : seed_i;
      chk_state(m_state);
      n_checks++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL load_abort%0d: got busy=%b valid=%b expected 0/0", k, busy_o, valid_o);
      end
      for (int i = 0; i < 6; i++) begin
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || state_o !== m_state) begin
          n_fail++;
          $display("FAIL load_quiet: got valid=%b state=%h expected 0/%h", valid_o, state_o, m_state);
        end
      end
    end
  endtask

  // Request held high: accept, OUT_BITS steps, DONE, then the next accept -> period 6.
  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    req_i = 1'b1;
    en_i  = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if ((c % 6) >= 1 && (c % 6) <= 4) m_state = m_step(m_state);
      tick();
      if (valid_o === 1'b1) pulses++;
      chk_state(m_state);
      n_checks++;
      if (valid_o !== ((c % 6) == 4)) begin
        n_fail++;
        $display("FAIL b2b_valid c%0d: got %b expected %b", c, valid_o, (c % 6) == 4);
      end
    end
    req_i = 1'b0;
    en_i  = 1'b0;
    tick();
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 3", pulses);
    end
  endtask

`ifdef LFSR_WRAP_DETECT_EN
  task automatic test_wrap();
    logic [3:0] s;
    bit seen [16];
    int since, distinct;
    s = 4'h1; since = 0; distinct = 0;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    en4 = 1'b1;
    for (int i = 0; i < 45; i++) begin
      s = (s >> 1) ^ (s[0] ? 4'hC : 4'h0);
      since++;
      tick();
      n_checks++;
      if (state4 !== s || state4 === 4'h0 || wrap4 !== (s == 4'h1)) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got state=%h wrap=%b expected %h/%b", i, state4, wrap4, s, s == 4'h1);
      end
      if (s == 4'h1) begin
        n_checks++;
        if (period4 !== 4'(since) || since != 15) begin
          n_fail++;
          $display("FAIL wrap_period: got %0d expected 15 (steps %0d)", period4, since);
        end
        since = 0;
      end
      if (!seen[state4]) distinct++;
      seen[state4] = 1'b1;
    end
    en4 = 1'b0;
    n_checks++;
    if (distinct != 15 || seen[0]) begin
      n_fail++;
      $display("FAIL wrap_visit: got %0d states zero=%b expected 15/0", distinct, seen[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_draw();
    test_req_with_en();
    test_load_abort();
    test_back_to_back();
`ifdef LFSR_WRAP_DETECT_EN
    test_reset();
    test_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
